// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory request, buffers
// one fetched word for IF/ID, and handles EX redirects, including in-flight drops.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] target_q, target_d;
    logic        valid_q, valid_d;
    logic        flush_q;
    logic [31:0] redirect_tgt;
    logic        consume;

    assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
    assign consume      = valid_q && !stall_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ifpc_d     = ifpc_q;
        target_d   = target_q;
        valid_d    = valid_q;
        imem_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_i) begin
                    pc_d    = redirect_tgt;
                    valid_d = 1'b0;
                end
            end
            FETCH: begin
                imem_req_o = !valid_q || !stall_i;
                if (redirect_i) begin
                    valid_d = 1'b0;
                    // An unacked request cannot be withdrawn; park the target until it returns.
                    if (imem_req_o && !imem_ack_i) begin
                        target_d = redirect_tgt;
                        state_d  = DROP;
                    end else begin
                        pc_d = redirect_tgt;
                    end
                end else if (imem_req_o && imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            DROP: begin
                imem_req_o = 1'b1;
                valid_d    = 1'b0;
                if (redirect_i) begin
                    target_d = redirect_tgt;
                end
                if (imem_ack_i) begin
                    pc_d    = redirect_i ? redirect_tgt : target_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            ifpc_q   <= '0;
            target_q <= '0;
            valid_q  <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            flush_q  <= redirect_i;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign if_valid_o  = valid_q;
    assign if_instr_o  = instr_q;
    assign if_pc_o     = ifpc_q;
    assign flush_o     = flush_q;

endmodule
